// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle and sequencer state type for the
// pipelined RV32 decode/control block.
package ctrl_pkg;

   localparam logic [6:0] OP_NOP   = 7'b0000000;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_FN  = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;

   // ResultSrc: ALU, data memory, PC+4 (links), ImmExt (lui)
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic       mul_div;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_t;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// D-stage decode inputs, hazard controls and registered E-stage control
// outputs of the main control block.
interface decode_ctrl_pipe_if;
   logic [6:0] opcodeD;
   logic [2:0] funct3D;
   logic [6:0] funct7D;
   logic       FlushE;
   logic [2:0] ImmSrcD;
   logic       RegWriteE;
   logic       MemWriteE;
   logic       JumpE;
   logic       BranchE;
   logic       ALUSrcAE;
   logic [1:0] ALUSrcBE;
   logic [1:0] ResultSrcE;
   logic [1:0] ALUOpE;
   logic       MulDivE;
   logic       IllegalE;
   logic       StallMD;
   logic       MulDivDoneE;

   modport master (
      output opcodeD, funct3D, funct7D, FlushE,
      input  ImmSrcD, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE,
             ALUSrcBE, ResultSrcE, ALUOpE, MulDivE, IllegalE, StallMD,
             MulDivDoneE
   );

   modport slave (
      input  opcodeD, funct3D, funct7D, FlushE,
      output ImmSrcD, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE,
             ALUSrcBE, ResultSrcE, ALUOpE, MulDivE, IllegalE, StallMD,
             MulDivDoneE
   );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle RV32M sequencer: holds the E stage for MUL_LAT/DIV_LAT cycles
// and pulses done on the cycle the result is valid.
//   state | meaning
//   IDLE  | no M-op in flight; an M-op arriving in E starts the stall at once
//   BUSY  | M-op executing, down-counter running, stall asserted
//   DONE  | result valid, stall released, E reloads on the next edge
module md_sequencer
   import ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_mul_div_e,
   input  logic i_div_e,
   input  logic i_flush_e,
   output logic o_stall_md,
   output logic o_md_done_e
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_stall_md  = 1'b0;
      o_md_done_e = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_mul_div_e && !i_flush_e) begin
               o_stall_md  = 1'b1;
               w_cnt_nxt   = i_div_e ? DIV_LOAD : MUL_LOAD;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (i_flush_e) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               o_stall_md = 1'b1;
               w_cnt_nxt  = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            // A flush here kills the result, so no done pulse escapes
            o_md_done_e = !i_flush_e;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Main control for the pipelined RV32 core: D-stage decode, ImmSrcD, and the
// ID/EX control register with flush/hold driven by the mul/div sequencer.
module decode_ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter bit EN_MEXT = 1'b1,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33
) (
   input  logic              clk,
   input  logic              reset_n,
   decode_ctrl_pipe_if.slave bus
);

   ctrl_t      w_ctrl_d;
   ctrl_t      r_ctrl_e;
   logic [2:0] w_imm_src;
   logic       w_is_mext;
   logic       r_div_e;
   logic       w_stall_md;
   logic       w_md_done_e;
   logic       w_unused_f3;

   assign w_is_mext   = (bus.funct7D == FUNCT7_MEXT);
   assign w_unused_f3 = ^bus.funct3D[1:0];

   always_comb begin
      w_ctrl_d  = CTRL_BUBBLE;
      w_imm_src = IMM_I;
      case (bus.opcodeD)
         OP_NOP: w_ctrl_d = CTRL_BUBBLE;
         OP_LOAD: begin
            w_ctrl_d.reg_write  = 1'b1;
            w_ctrl_d.alu_src_b  = SRCB_IMM;
            w_ctrl_d.result_src = RES_MEM;
         end
         OP_STORE: begin
            w_ctrl_d.mem_write = 1'b1;
            w_ctrl_d.alu_src_b = SRCB_IMM;
            w_imm_src          = IMM_S;
         end
         OP_R: begin
            if (w_is_mext && !EN_MEXT) begin
               w_ctrl_d.illegal = 1'b1;
            end else begin
               w_ctrl_d.reg_write = 1'b1;
               w_ctrl_d.alu_src_b = SRCB_REG;
               w_ctrl_d.alu_op    = ALUOP_FN;
               w_ctrl_d.mul_div   = w_is_mext;
            end
         end
         OP_B: begin
            w_ctrl_d.branch = 1'b1;
            w_ctrl_d.alu_op = ALUOP_BR;
            w_imm_src       = IMM_B;
         end
         OP_I: begin
            w_ctrl_d.reg_write = 1'b1;
            w_ctrl_d.alu_src_b = SRCB_IMM;
            w_ctrl_d.alu_op    = ALUOP_FN;
         end
         OP_LUI: begin
            w_ctrl_d.reg_write  = 1'b1;
            w_ctrl_d.result_src = RES_IMM;
            w_imm_src           = IMM_U;
         end
         OP_AUIPC: begin
            w_ctrl_d.reg_write = 1'b1;
            w_ctrl_d.alu_src_a = 1'b1;
            w_ctrl_d.alu_src_b = SRCB_IMM;
            w_ctrl_d.alu_op    = ALUOP_ADD;
            w_imm_src          = IMM_U;
         end
         OP_JALR: begin
            w_ctrl_d.reg_write  = 1'b1;
            w_ctrl_d.jump       = 1'b1;
            w_ctrl_d.alu_src_b  = SRCB_IMM;
            w_ctrl_d.result_src = RES_PC4;
         end
         OP_JAL: begin
            w_ctrl_d.reg_write  = 1'b1;
            w_ctrl_d.jump       = 1'b1;
            w_ctrl_d.result_src = RES_PC4;
            w_imm_src           = IMM_J;
         end
         default: w_ctrl_d.illegal = 1'b1;
      endcase
   end

   assign bus.ImmSrcD = w_imm_src;

   // funct3[2] is kept alongside the bundle only to pick mul vs div latency
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ctrl_e <= CTRL_BUBBLE;
         r_div_e  <= 1'b0;
      end else if (bus.FlushE) begin
         r_ctrl_e <= CTRL_BUBBLE;
         r_div_e  <= 1'b0;
      end else if (!w_stall_md) begin
         r_ctrl_e <= w_ctrl_d;
         r_div_e  <= bus.funct3D[2];
      end
   end

   md_sequencer #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_mul_div_e (r_ctrl_e.mul_div),
      .i_div_e     (r_div_e),
      .i_flush_e   (bus.FlushE),
      .o_stall_md  (w_stall_md),
      .o_md_done_e (w_md_done_e)
   );

   assign bus.RegWriteE   = r_ctrl_e.reg_write;
   assign bus.MemWriteE   = r_ctrl_e.mem_write;
   assign bus.JumpE       = r_ctrl_e.jump;
   assign bus.BranchE     = r_ctrl_e.branch;
   assign bus.ALUSrcAE    = r_ctrl_e.alu_src_a;
   assign bus.ALUSrcBE    = r_ctrl_e.alu_src_b;
   assign bus.ResultSrcE  = r_ctrl_e.result_src;
   assign bus.ALUOpE      = r_ctrl_e.alu_op;
   assign bus.MulDivE     = r_ctrl_e.mul_div;
   assign bus.IllegalE    = r_ctrl_e.illegal;
   assign bus.StallMD     = w_stall_md;
   assign bus.MulDivDoneE = w_md_done_e;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: an EN_MEXT=1 instance checked
// against an E-residency model and an EN_MEXT=0 instance fed the same D stream.
module tb_decode_ctrl_pipe;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 33;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
   } instr_t;

   typedef struct {
      logic [12:0] ctrl;
      logic [2:0]  imm;
      int          stalls;
      bit          md;
   } exp_t;

   logic clk;
   logic reset_n;

   decode_ctrl_pipe_if if0 ();
   decode_ctrl_pipe_if if1 ();

   decode_ctrl_pipe #(.EN_MEXT(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if0.slave)
   );

   decode_ctrl_pipe #(.EN_MEXT(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_nom (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if1.slave)
   );

   assign if1.opcodeD = if0.opcodeD;
   assign if1.funct3D = if0.funct3D;
   assign if1.funct7D = if0.funct7D;
   assign if1.FlushE  = if0.FlushE;

   wire [12:0] e0 = {if0.RegWriteE, if0.MemWriteE, if0.JumpE, if0.BranchE, if0.ALUSrcAE,
                     if0.ALUSrcBE, if0.ResultSrcE, if0.ALUOpE, if0.MulDivE, if0.IllegalE};
   wire [12:0] e1 = {if1.RegWriteE, if1.MemWriteE, if1.JumpE, if1.BranchE, if1.ALUSrcAE,
                     if1.ALUSrcBE, if1.ResultSrcE, if1.ALUOpE, if1.MulDivE, if1.IllegalE};

   int   n_tests = 0;
   int   n_fail  = 0;
   int   e_left  = 1;
   int   stall_seen = 0;
   bit   mon_en  = 1'b0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t m0, m1, m1n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [12:0] mk(input bit rw, input bit mw, input bit j, input bit b,
                                      input bit asa, input logic [1:0] asb,
                                      input logic [1:0] rs, input logic [1:0] aop);
      return {rw, mw, j, b, asa, asb, rs, aop, 2'b00};
   endfunction

   function automatic instr_t mki(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      instr_t d;
      d.op = op;
      d.f3 = f3;
      d.f7 = f7;
      return d;
   endfunction

   // Expected E-stage residency for one instruction under a given EN_MEXT
   function automatic exp_t ref_model(input instr_t d, input bit en);
      exp_t e;
      bit   mop;
      e.ctrl   = '0;
      e.imm    = 3'b000;
      e.stalls = 0;
      e.md     = 1'b0;
      mop = (d.op == 7'b0110011) && (d.f7 == 7'b0000001);
      case (d.op)
         7'b0000011: e.ctrl = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
         7'b0100011: begin e.ctrl = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00); e.imm = 3'b001; end
         7'b0110011: begin
            if (mop && !en) e.ctrl = 13'd1;
            else begin
               e.ctrl    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
               e.ctrl[1] = mop;
               e.md      = mop;
            end
         end
         7'b1100011: begin e.ctrl = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01); e.imm = 3'b010; end
         7'b0010011: e.ctrl = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10);
         7'b0110111: begin e.ctrl = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00); e.imm = 3'b100; end
         7'b0010111: begin e.ctrl = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00); e.imm = 3'b100; end
         7'b1100111: e.ctrl = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
         7'b1101111: begin e.ctrl = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00); e.imm = 3'b011; end
         7'b0000000: e.ctrl = '0;
         default:    e.ctrl = 13'd1;
      endcase
      if (e.md) e.stalls = d.f3[2] ? DIV_LAT : MUL_LAT;
      return e;
   endfunction

   function automatic exp_t bubble();
      return ref_model(mki(7'h00, 3'h0, 7'h00), 1'b1);
   endfunction

   function automatic instr_t rand_instr();
      logic [6:0] ops [10];
      instr_t     d;
      int         k;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
              7'b0110111, 7'b0010111, 7'b1100111, 7'b1101111, 7'b0000000};
      k    = $urandom_range(0, 12);
      d.f3 = 3'($urandom);
      d.f7 = 7'($urandom);
      if (k < 10) d.op = ops[k];
      else if (k == 10) d.op = 7'($urandom);
      else begin
         d.op = 7'b0110011;
         d.f7 = 7'b0000001;
      end
      if (d.op == 7'b0110011 && k < 10) begin
         case ($urandom_range(0, 2))
            0:       d.f7 = 7'b0000000;
            1:       d.f7 = 7'b0100000;
            default: d.f7 = 7'b0000001;
         endcase
      end
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input instr_t d, input bit fl);
      if0.opcodeD = d.op;
      if0.funct3D = d.f3;
      if0.funct7D = d.f7;
      if0.FlushE  = fl;
   endtask

   task automatic do_reset(input int n);
      mon_en  = 1'b0;
      reset_n = 1'b0;
      drive(mki(7'h00, 3'h0, 7'h00), 1'b0);
      repeat (n) @(posedge clk);
      #1;
      chk("rst_e_ctrl", 32'(e0), 32'd0);
      chk("rst_stall", 32'(if0.StallMD), 32'd0);
      chk("rst_done", 32'(if0.MulDivDoneE), 32'd0);
      chk("rst_e1_ctrl", 32'(e1), 32'd0);
      q0.delete();
      q1.delete();
      q0.push_back(bubble());
      q1.push_back(bubble());
      stall_seen = 0;
      e_left     = 1;
      reset_n    = 1'b1;
      mon_en     = 1'b1;
   endtask

   // One clock of D presentation; the model decides whether E accepts it
   task automatic step(input instr_t d, input bit fl, output bit acc);
      exp_t e;
      drive(d, fl);
      e = ref_model(d, 1'b1);
      #1;
      chk("imm_src", 32'(if0.ImmSrcD), 32'(e.imm));
      acc = 1'b0;
      if (fl) begin
         q0.push_back(bubble());
         e_left = 1;
         acc    = 1'b1;
      end else if (e_left > 1) begin
         e_left--;
      end else begin
         q0.push_back(e);
         e_left = e.stalls + 1;
         acc    = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input instr_t d);
      bit acc;
      acc = 1'b0;
      while (!acc) step(d, 1'b0, acc);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (q0.size() == 0) begin
               chk("q0_underflow_e_ctrl", 32'(e0), 32'hFFFF_FFFF);
            end else begin
               m0 = q0[0];
               chk("e_ctrl", 32'(e0), 32'(m0.ctrl));
               if (if0.FlushE) begin
                  chk("stall_on_flush", 32'(if0.StallMD), 32'd0);
                  chk("done_on_flush", 32'(if0.MulDivDoneE), 32'd0);
                  void'(q0.pop_front());
                  stall_seen = 0;
               end else if (stall_seen < m0.stalls) begin
                  chk("stall_window", 32'(if0.StallMD), 32'd1);
                  chk("done_in_stall", 32'(if0.MulDivDoneE), 32'd0);
                  stall_seen++;
               end else begin
                  chk("stall_release", 32'(if0.StallMD), 32'd0);
                  chk("md_done", 32'(if0.MulDivDoneE), 32'(m0.md));
                  void'(q0.pop_front());
                  stall_seen = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (q1.size() == 0) begin
               chk("q1_underflow_e1_ctrl", 32'(e1), 32'hFFFF_FFFF);
            end else begin
               m1 = q1.pop_front();
               chk("e1_ctrl", 32'(e1), 32'(m1.ctrl));
            end
            chk("e1_stall", 32'(if1.StallMD), 32'd0);
            chk("e1_done", 32'(if1.MulDivDoneE), 32'd0);
            m1n = ref_model(instr_t'({if1.opcodeD, if1.funct3D, if1.funct7D}), 1'b0);
            chk("e1_imm", 32'(if1.ImmSrcD), 32'(m1n.imm));
            if (if1.FlushE) q1.push_back(bubble());
            else q1.push_back(m1n);
         end
      end
   end

   initial begin
      instr_t nop, lw, mul, dv, d;
      bit     acc;
      nop = mki(7'b0000000, 3'b000, 7'b0000000);
      lw  = mki(7'b0000011, 3'b010, 7'b0000000);
      mul = mki(7'b0110011, 3'b000, 7'b0000001);
      dv  = mki(7'b0110011, 3'b100, 7'b0000001);

      reset_n = 1'b0;
      drive(nop, 1'b0);
      do_reset(2);

      issue(lw);
      issue(mki(7'b1101111, 3'b000, 7'b0000000));
      issue(mki(7'b0100011, 3'b010, 7'b0000000));
      issue(mki(7'b0110011, 3'b000, 7'b0000000));
      issue(mki(7'b0110011, 3'b000, 7'b0100000));
      issue(mki(7'b1100011, 3'b001, 7'b0000000));
      issue(mki(7'b0010011, 3'b000, 7'b0000000));
      issue(mki(7'b0110111, 3'b000, 7'b0000000));
      issue(mki(7'b0010111, 3'b000, 7'b0000000));
      issue(mki(7'b1100111, 3'b000, 7'b0000000));
      issue(mki(7'b1111111, 3'b111, 7'b1111111));
      issue(nop);

      issue(mul);
      issue(lw);

      issue(mul);
      issue(dv);
      issue(lw);

      issue(mki(7'b0110011, 3'b101, 7'b0000001));
      repeat (5) step(nop, 1'b0, acc);
      step(nop, 1'b1, acc);
      issue(lw);
      issue(nop);

      issue(dv);
      repeat (3) step(nop, 1'b0, acc);
      do_reset(1);
      issue(lw);
      issue(nop);

      for (int i = 0; i < 250; i++) begin
         d = rand_instr();
         if ($urandom_range(0, 15) == 0) step(d, 1'b1, acc);
         else issue(d);
      end

      issue(nop);
      repeat (2) step(nop, 1'b0, acc);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Second-generation main control block for the pipelined RV32 core. It decodes opcode/funct3/funct7 into a control bundle and emits ImmSrcD combinationally for D-stage immediate extension. The bundle is registered into the ID/EX control register, which the block owns together with its flush and hold logic. A parametrised multi-cycle sequencer for RV32M mul/div holds the E stage and requests a pipeline stall for a configurable latency. Unimplemented encodings are flagged as illegal instead of producing don't-cares.

## Interface
- EN_MEXT, 1: 1 decodes RV32M (R-type, funct7=0000001); 0 treats those encodings as illegal.
- MUL_LAT, 3: E-stage stall cycles for mul/mulh/mulhsu/mulhu (funct3[2]=0); must be ≥2.
- DIV_LAT, 33: E-stage stall cycles for div/divu/rem/remu (funct3[2]=1); must be ≥2.
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcodeD  in  7  instruction bits [6:0].
- funct3D  in  3  instruction bits [14:12].
- funct7D  in  7  instruction bits [31:25].
- FlushE  in  1  hazard unit: load bubble into ID/EX control register.
- ImmSrcD  out  3  combinational immediate select: I=000, S=001, B=010, J=011, U=100.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE  out  1 each  registered control.
- ALUSrcBE, ResultSrcE, ALUOpE  out  2 each  registered control.
- MulDivE  out  1  E holds an M-extension op; funct3 is carried by the datapath.
- IllegalE  out  1  E holds an undecodable instruction.
- StallMD  out  1  stall request to the hazard unit (stall F and D, hold E).
- MulDivDoneE  out  1  one-cycle pulse: mul/div result valid this cycle.

## Operation
- Decode: lw, sw, R, B, I-ALU, lui, auipc, jalr and jal keep the established encodings. Opcode 0000000 decodes to an all-zero bubble. M-op decodes as R-type plus MulDivD=1.
- Illegal: any other opcode, or an M-op with EN_MEXT=0, gives IllegalD=1, all other control 0, and ImmSrcD=000. No X is ever driven.
- ID/EX register priority: !reset_n > FlushE > StallMD (hold) > load decoded bundle.
- Sequencer FSM states:
  - IDLE: if MulDivE and not FlushE, assert StallMD, load cnt with LAT−1 (MUL_LAT or DIV_LAT chosen by registered funct3E[2]), and go to BUSY.
  - BUSY: StallMD=1 and cnt decrements. When cnt==1, go to DONE.
  - DONE: StallMD=0 and MulDivDoneE=1; ID/EX loads on the next edge; go to IDLE.
- StallMD is a combinational function of state, MulDivE and FlushE. It is 0 whenever FlushE=1.
- FlushE in BUSY or DONE sends the FSM to IDLE, clears cnt and bubbles E; no MulDivDoneE is issued.
- Back-to-back M-ops: the second op enters E on the edge leaving DONE. IDLE then immediately asserts the stall, with no gap cycle.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

## Timing
- ImmSrcD: 0-cycle, combinational from opcodeD.
- E control is valid one cycle after D presentation, unless held or flushed.
- A non-M instruction spends exactly 1 cycle in E.
- An M-op spends LAT+1 cycles in E:
  - cycle t (entry): StallMD=1.
  - t+1 … t+LAT−1: StallMD=1.
  - t+LAT: StallMD=0 and MulDivDoneE=1.
- Reset values: all E outputs 0, IllegalE 0, MulDivE 0, state IDLE, cnt 0, StallMD 0, MulDivDoneE 0.
- Reset asserted mid-BUSY aborts at the next edge. The first cycle after reset release shows a bubble in E.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_B, OP_I, OP_LUI, OP_AUIPC, OP_JALR, OP_JAL).
  - ImmSrc and ALUOp encodings.
  - FUNCT7_MEXT.
  - packed struct ctrl_t for the control bundle, and its CTRL_BUBBLE constant.
  - enum md_state_t {IDLE, BUSY, DONE}.
- Sub-module md_sequencer (FSM plus counter; inputs MulDivE, funct3E[2], FlushE; outputs StallMD, MulDivDoneE).
- Decode and the ID/EX register stay in the top module.

## Test plan
- Decode sweep: opcode 0000011 → ImmSrcD=000, E next cycle shows RegWriteE=1, ALUSrcBE=01, ResultSrcE=01. Opcode 1101111 → JumpE=1, ResultSrcE=10, ImmSrcD=011.
- mul with MUL_LAT=3: StallMD high for 3 cycles from entry, MulDivDoneE at entry+3, next instruction enters E at entry+4.
- div with DIV_LAT=33 and FlushE pulsed at entry+5: the flushed cycle and all following cycles show StallMD=0, the next cycle has E=bubble, MulDivDoneE is never asserted, state is IDLE.
- Back-to-back mul, div: stall windows of 3 and 33 cycles, separated by exactly one DONE cycle.
- EN_MEXT=0, R-type with funct7=0000001, and separately opcode 1111111: IllegalE=1, RegWriteE=0, MemWriteE=0, StallMD never asserted.
- reset_n low during BUSY: all E outputs 0 and StallMD 0 after the edge; a following lw decodes normally.
